// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipeline: passes ALU results through to writeback
// or runs a request/done handshake with data memory for word loads and stores.
// Misaligned or conflicting memory controls and memory timeouts park the stage
// in a sticky error state that only reset clears.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        err,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_rd,
    output logic        dmem_wr,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_stall,
    input  logic        dmem_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Last counter value allowed in WAIT; no done by then means timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        op_rd_q, op_rd_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        wb_valid_q, wb_valid_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        bad_op;

    assign mem_op = mem_read | mem_write;
    assign bad_op = (mem_read & mem_write) | (mem_op & alu_result[0]);

    // Next-state and register updates for the access sequencer.
    always_comb begin
        state_d    = state_q;
        op_rd_d    = op_rd_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!mem_op) begin
                        wb_data_d  = alu_result;
                        wb_valid_d = 1'b1;
                    end else if (bad_op) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        op_rd_d = mem_read;
                        op_wr_d = mem_write;
                        addr_d  = alu_result;
                        wdata_d = store_data;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!dmem_stall) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_done) begin
                    wb_data_d  = op_rd_q ? dmem_rdata : addr_q;
                    wb_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_rd_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_rd_q    <= op_rd_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
        end
    end

    // Requests and upstream stall are decoded combinationally from state.
    always_comb begin
        dmem_rd = (state_q == ST_ISSUE) & op_rd_q;
        dmem_wr = (state_q == ST_ISSUE) & op_wr_q;
        stall   = ((state_q == ST_IDLE) & in_valid & mem_op)
                | (state_q == ST_ISSUE)
                | ((state_q == ST_WAIT) & ~dmem_done)
                | (state_q == ST_ERR);
    end

    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_data    = wb_data_q;
    assign wb_valid   = wb_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        err;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [15:0] dmem_rdata;
    logic        dmem_stall;
    logic        dmem_done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_acc = 0;
    int stall_cnt = 0;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .alu_result (alu_result),
        .store_data (store_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .err        (err),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_rdata (dmem_rdata),
        .dmem_stall (dmem_stall),
        .dmem_done  (dmem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dmem_rd) rd_cnt++;
        if (dmem_wr) wr_cnt++;
        if (dmem_wr && !dmem_stall) wr_acc++;
        if (stall) stall_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 0; mem_read = 0; mem_write = 0; alu_result = 16'h0; store_data = 16'h0;
        dmem_rdata = 16'h0; dmem_stall = 0; dmem_done = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %0h exp 0", wb_valid); end
        checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0000", wb_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", err); end
        checks++; if ({dmem_rd, dmem_wr} !== 2'b00) begin errors++; $display("FAIL rst_req got %b exp 00", {dmem_rd, dmem_wr}); end
        checks++; if ({dmem_addr, dmem_wdata} !== 32'h0) begin errors++; $display("FAIL rst_dmem got %h exp 0", {dmem_addr, dmem_wdata}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall); end
    endtask

    task automatic test_pass_through();
        in_valid = 1; alu_result = 16'h1234;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %0h exp 0", stall); end
        step();
        in_valid = 0;
        #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL pass_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL pass_wb_data got %h exp 1234", wb_data); end
        checks++; if ({dmem_rd, dmem_wr} !== 2'b00) begin errors++; $display("FAIL pass_req got %b exp 00", {dmem_rd, dmem_wr}); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pass_wb_drop got %0h exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; alu_result = 16'h1111;
        step();
        alu_result = 16'h2222;
        #1;
        checks++; if ({wb_valid, wb_data} !== {1'b1, 16'h1111}) begin errors++; $display("FAIL b2b_first got %0h/%h exp 1/1111", wb_valid, wb_data); end
        step();
        in_valid = 0;
        #1;
        checks++; if ({wb_valid, wb_data} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL b2b_second got %0h/%h exp 1/2222", wb_valid, wb_data); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0h exp 0", wb_valid); end
    endtask

    task automatic test_load();
        int rd0, st0;
        rd0 = rd_cnt; st0 = stall_cnt;
        in_valid = 1; mem_read = 1; alu_result = 16'h0040;
        #1;
        checks++; if ({stall, dmem_rd} !== 2'b10) begin errors++; $display("FAIL load_accept got %b exp 10", {stall, dmem_rd}); end
        step();                                  // cycle N+1, ISSUE
        in_valid = 0; mem_read = 0;
        #1;
        checks++; if ({dmem_rd, dmem_wr, dmem_addr} !== {2'b10, 16'h0040}) begin errors++; $display("FAIL load_issue got %b/%h exp 10/0040", {dmem_rd, dmem_wr}, dmem_addr); end
        step();                                  // cycle N+2, WAIT
        dmem_done = 1; dmem_rdata = 16'hBEEF;
        #1;
        checks++; if ({stall, dmem_rd} !== 2'b00) begin errors++; $display("FAIL load_wait got %b exp 00", {stall, dmem_rd}); end
        step();                                  // cycle N+3
        dmem_done = 0;
        in_valid = 1; alu_result = 16'h7777;
        #1;
        checks++; if ({wb_valid, wb_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL load_wb got %0h/%h exp 1/beef", wb_valid, wb_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_next_stall got %0h exp 0", stall); end
        step();
        in_valid = 0;
        #1;
        checks++; if ({wb_valid, wb_data} !== {1'b1, 16'h7777}) begin errors++; $display("FAIL load_next_wb got %0h/%h exp 1/7777", wb_valid, wb_data); end
        checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL load_rd_cycles got %0d exp 1", rd_cnt - rd0); end
        checks++; if (stall_cnt - st0 !== 2) begin errors++; $display("FAIL load_stall_cycles got %0d exp 2", stall_cnt - st0); end
    endtask

    task automatic test_store_stalled();
        int wr0, acc0, rd0;
        wr0 = wr_cnt; acc0 = wr_acc; rd0 = rd_cnt;
        in_valid = 1; mem_write = 1; alu_result = 16'h0010; store_data = 16'h00FF;
        step();                                  // ISSUE
        in_valid = 0; mem_write = 0; store_data = 16'h0;
        dmem_stall = 1;
        repeat (3) step();
        dmem_stall = 0;
        #1;
        checks++; if ({dmem_wr, dmem_wdata, dmem_addr} !== {1'b1, 16'h00FF, 16'h0010}) begin errors++; $display("FAIL store_req got %0h/%h/%h exp 1/00ff/0010", dmem_wr, dmem_wdata, dmem_addr); end
        step();                                  // WAIT
        dmem_done = 1;
        step();
        dmem_done = 0;
        #1;
        checks++; if ({wb_valid, wb_data} !== {1'b1, 16'h0010}) begin errors++; $display("FAIL store_wb got %0h/%h exp 1/0010", wb_valid, wb_data); end
        checks++; if (wr_cnt - wr0 !== 4) begin errors++; $display("FAIL store_wr_cycles got %0d exp 4", wr_cnt - wr0); end
        checks++; if (wr_acc - acc0 !== 1) begin errors++; $display("FAIL store_writes got %0d exp 1", wr_acc - acc0); end
        checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL store_rd_cycles got %0d exp 0", rd_cnt - rd0); end
    endtask

    task automatic test_misaligned();
        int rd0;
        rd0 = rd_cnt;
        in_valid = 1; mem_read = 1; alu_result = 16'h0041;
        step();
        in_valid = 0; mem_read = 0;
        #1;
        checks++; if ({err, stall} !== 2'b11) begin errors++; $display("FAIL misal_err got %b exp 11", {err, stall}); end
        dmem_done = 1;
        repeat (3) step();
        dmem_done = 0;
        #1;
        checks++; if ({err, stall, wb_valid} !== 3'b110) begin errors++; $display("FAIL misal_sticky got %b exp 110", {err, stall, wb_valid}); end
        checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL misal_rd_cycles got %0d exp 0", rd_cnt - rd0); end
        do_reset();
        #1;
        checks++; if ({err, stall} !== 2'b00) begin errors++; $display("FAIL misal_clear got %b exp 00", {err, stall}); end
        // Conflicting read+write on an aligned address.
        in_valid = 1; mem_read = 1; mem_write = 1; alu_result = 16'h0020;
        step();
        in_valid = 0; mem_read = 0; mem_write = 0;
        #1;
        checks++; if ({err, dmem_rd, dmem_wr} !== 3'b100) begin errors++; $display("FAIL conflict_err got %b exp 100", {err, dmem_rd, dmem_wr}); end
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL conflict_clear got %0h exp 0", err); end
    endtask

    task automatic test_timeout();
        in_valid = 1; mem_read = 1; alu_result = 16'h0080;
        step();                                  // ISSUE
        in_valid = 0; mem_read = 0;
        step();                                  // WAIT cycle 1
        repeat (14) step();                      // WAIT cycle 15
        #1;
        checks++; if ({err, stall} !== 2'b01) begin errors++; $display("FAIL timeout_early got %b exp 01", {err, stall}); end
        step();
        #1;
        checks++; if ({err, stall, wb_valid} !== 3'b110) begin errors++; $display("FAIL timeout_err got %b exp 110", {err, stall, wb_valid}); end
        do_reset();
        // Same access, done arrives in the 15th WAIT cycle.
        in_valid = 1; mem_read = 1; alu_result = 16'h0080;
        step();
        in_valid = 0; mem_read = 0;
        step();
        repeat (14) step();
        dmem_done = 1; dmem_rdata = 16'h5A5A;
        step();
        dmem_done = 0;
        #1;
        checks++; if ({err, wb_valid, wb_data} !== {2'b01, 16'h5A5A}) begin errors++; $display("FAIL timeout_last got %b/%h exp 01/5a5a", {err, wb_valid}, wb_data); end
        step();
        checks++; if ({err, stall} !== 2'b00) begin errors++; $display("FAIL timeout_after got %b exp 00", {err, stall}); end
    endtask

    task automatic test_reset_mid_access();
        // Reset while the request is being presented.
        in_valid = 1; mem_read = 1; alu_result = 16'h0100;
        step();
        in_valid = 0; mem_read = 0;
        rst = 1;
        #1;
        checks++; if (dmem_rd !== 1'b1) begin errors++; $display("FAIL rst_issue_pre got %0h exp 1", dmem_rd); end
        step();
        rst = 0;
        #1;
        checks++; if ({dmem_rd, dmem_addr} !== {1'b0, 16'h0}) begin errors++; $display("FAIL rst_issue_post got %0h/%h exp 0/0000", dmem_rd, dmem_addr); end
        // Reset mid-WAIT, then a late done.
        in_valid = 1; mem_write = 1; alu_result = 16'h0200; store_data = 16'hCAFE;
        step();
        in_valid = 0; mem_write = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        dmem_done = 1; dmem_rdata = 16'h9999;
        step();
        dmem_done = 0;
        #1;
        checks++; if ({wb_valid, err, stall, dmem_rd, dmem_wr} !== 5'b0) begin errors++; $display("FAIL rst_wait_ctrl got %b exp 00000", {wb_valid, err, stall, dmem_rd, dmem_wr}); end
        checks++; if ({wb_data, dmem_addr, dmem_wdata} !== 48'h0) begin errors++; $display("FAIL rst_wait_data got %h exp 0", {wb_data, dmem_addr, dmem_wdata}); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_load();
        test_store_stalled();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so a hung run still ends with a reported failure.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
